// File: rtl/sram_like_pkg.sv
// Shared types and constants for the SRAM-like bus responder: access sizes,
// the response-entry struct carried by the delay line, and the stall LFSR seed.
package sram_like_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
  } resp_entry_t;

  localparam resp_entry_t RESP_IDLE = '{valid: 1'b0, rdata: 32'h0};

  // Byte lanes touched by an access; all-zero marks a misaligned or illegal request.
  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] en;
    en = 4'b0000;
    case (size)
      SIZE_BYTE: en = 4'b0001 << lo;
      SIZE_HALF: en = lo[0] ? 4'b0000 : (lo[1] ? 4'b1100 : 4'b0011);
      SIZE_WORD: en = (lo == 2'b00) ? 4'b1111 : 4'b0000;
      default:   en = 4'b0000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/sram_like_delay_line.sv
// Fixed-latency response pipe: LATENCY stages of response entries, cleared
// synchronously on rst so in-flight responses are dropped.
module sram_like_delay_line
  import sram_like_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  resp_entry_t in_entry,
  output resp_entry_t out_entry
);

  resp_entry_t stage_q [LATENCY];
  resp_entry_t stage_d [LATENCY];

  always_comb begin
    stage_d[0] = in_entry;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= RESP_IDLE;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_entry = stage_q[LATENCY-1];

endmodule

// File: rtl/sram_like_slave.sv
// SRAM-like bus responder with a word-organised memory and fixed in-order read latency.
// Optional SRAM_LIKE_SLAVE_STALL_EN adds an LFSR that randomly withholds addr_ok.
module sram_like_slave
  import sram_like_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic [31:0] rdata,
  output logic        data_ok
);

  localparam int              PEND_W   = $clog2(OUTSTANDING + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(OUTSTANDING);

  logic [31:0]       mem_q [0:(1<<ADDR_W)-1];
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              stall;
  logic              hs;
  logic [ADDR_W-1:0] word_idx;
  logic [3:0]        lane_en;
  logic [3:0]        wr_lanes;
  logic              legal;
  resp_entry_t       push_entry;
  resp_entry_t       head_entry;
  logic              unused_addr;

  // Upper address bits alias onto the same words.
  assign unused_addr = ^addr[31:ADDR_W+2];

`ifdef SRAM_LIKE_SLAVE_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  assign addr_ok  = req && !rst && (pending_q < PEND_MAX) && !stall;
  assign hs       = req && addr_ok;
  assign word_idx = addr[ADDR_W+1:2];
  assign lane_en  = lane_enables(size, addr[1:0]);
  assign legal    = |lane_en;
  assign wr_lanes = (hs && wr) ? lane_en : 4'b0000;

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_lanes[k]) begin
        mem_q[word_idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // Reads capture the whole word now; writes and bad requests answer with zero.
  always_comb begin
    push_entry = RESP_IDLE;
    if (hs) begin
      push_entry.valid = 1'b1;
      if (!wr && legal) begin
        push_entry.rdata = mem_q[word_idx];
      end
    end
  end

  sram_like_delay_line #(
    .LATENCY (LATENCY)
  ) u_delay_line (
    .clk       (clk),
    .rst       (rst),
    .in_entry  (push_entry),
    .out_entry (head_entry)
  );

  assign data_ok = head_entry.valid;
  assign rdata   = head_entry.valid ? head_entry.rdata : 32'h0;

  always_comb begin
    pending_d = pending_q;
    case ({hs, data_ok})
      2'b10:   pending_d = pending_q + 1'b1;
      2'b01:   pending_d = pending_q - 1'b1;
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_sram_like_slave.sv
// Self-checking bench: two responders (LATENCY 2 and 4) against a queue/array reference model.
module tb_sram_like_slave;

  localparam int OUTS = 2;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        req     [2];
  logic        wr      [2];
  logic [1:0]  size    [2];
  logic [31:0] addr    [2];
  logic [31:0] wdata   [2];
  logic        addr_ok [2];
  logic        data_ok [2];
  logic [31:0] rdata   [2];

  always #5 clk = ~clk;

  sram_like_slave #(.ADDR_W(12), .LATENCY(2), .OUTSTANDING(2)) u_a (
    .clk(clk), .rst(rst), .req(req[0]), .wr(wr[0]), .size(size[0]), .addr(addr[0]),
    .wdata(wdata[0]), .addr_ok(addr_ok[0]), .rdata(rdata[0]), .data_ok(data_ok[0]));

  sram_like_slave #(.ADDR_W(8), .LATENCY(4), .OUTSTANDING(2)) u_b (
    .clk(clk), .rst(rst), .req(req[1]), .wr(wr[1]), .size(size[1]), .addr(addr[1]),
    .wdata(wdata[1]), .addr_ok(addr_ok[1]), .rdata(rdata[1]), .data_ok(data_ok[1]));

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q [2][$];
  int          pend_m [2];
  logic [31:0] mem_m [2][32];
  logic [15:0] lfsr_m;
  int          cyc;
  int          errors = 0;
  int          checks = 0;
  logic        obs_ok [2];
  int          last_acc_cyc [2];
  int          last_dok_cyc [2];
  int          acc_cnt [2];
  int          dok_cnt [2];
  logic [31:0] last_rdata [2];
  logic [31:0] rd_log [2][$];

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic logic stall_m();
`ifdef SRAM_LIKE_SLAVE_STALL_EN
    return lfsr_m[0];
`else
    return 1'b0;
`endif
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return 1 << int'(sz);
  endfunction

  function automatic logic ok_req(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b0;
    return (int'(a[1:0]) % nbytes(sz)) == 0;
  endfunction

  function automatic logic [31:0] init_word(input int d, input int i);
    return 32'(((d + 1) << 24) | (i << 16) | 16'hC0DE);
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs at negedge, then advance the model at posedge.
  task automatic tick();
    logic        hs   [2];
    logic        dok  [2];
    logic [31:0] resp [2];
    exp_t        e;
    int          lo;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      logic        exp_ok;
      logic [31:0] exp_rd;
      exp_ok = req[d] && !rst && (pend_m[d] < OUTS) && !stall_m();
      dok[d] = (exp_q[d].size() > 0) && (exp_q[d][0].due == cyc);
      exp_rd = dok[d] ? exp_q[d][0].data : 32'h0;
      check32($sformatf("addr_ok[%0d]@%0d", d, cyc), 32'(addr_ok[d]), 32'(exp_ok));
      check32($sformatf("data_ok[%0d]@%0d", d, cyc), 32'(data_ok[d]), 32'(dok[d]));
      check32($sformatf("rdata[%0d]@%0d", d, cyc), rdata[d], exp_rd);
      obs_ok[d] = addr_ok[d] && req[d];
      if (obs_ok[d]) begin
        last_acc_cyc[d] = cyc;
        acc_cnt[d]++;
      end
      if (data_ok[d]) begin
        last_dok_cyc[d] = cyc;
        dok_cnt[d]++;
        last_rdata[d] = rdata[d];
        rd_log[d].push_back(rdata[d]);
      end
      hs[d]   = exp_ok;
      resp[d] = (!wr[d] && ok_req(size[d], addr[d])) ? mem_m[d][addr[d][6:2]] : 32'h0;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        exp_q[d].delete();
        pend_m[d] = 0;
      end else begin
        if (dok[d]) begin
          void'(exp_q[d].pop_front());
          pend_m[d]--;
        end
        if (hs[d]) begin
          e.due  = cyc + lat_of(d);
          e.data = resp[d];
          exp_q[d].push_back(e);
          pend_m[d]++;
          if (wr[d] && ok_req(size[d], addr[d])) begin
            lo = int'(addr[d][1:0]);
            for (int b = lo; b < lo + nbytes(size[d]); b++) begin
              mem_m[d][addr[d][6:2]][8*b +: 8] = wdata[d][8*b +: 8];
            end
          end
        end
      end
    end
    lfsr_m = rst ? 16'hACE1 : {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    cyc++;
    #1;
  endtask

  task automatic issue(input int d, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    logic done;
    done    = 1'b0;
    req[d]  = 1'b1;
    wr[d]   = w;
    size[d] = sz;
    addr[d] = a;
    wdata[d] = wd;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      done = obs_ok[d];
    end
    req[d] = 1'b0;
    if (!done) check32("issue_timeout", 32'(done), 32'd1);
  endtask

  task automatic drain(input int d);
    for (int i = 0; i < 20 && exp_q[d].size() > 0; i++) tick();
    check32($sformatf("drain_empty[%0d]", d), 32'(exp_q[d].size()), 32'd0);
    tick();
  endtask

  initial begin
    int t0;
    int n;
    int acc_c [4];

    rst    = 1'b1;
    cyc    = 0;
    lfsr_m = 16'hACE1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; size[d] = SZ_W; addr[d] = '0; wdata[d] = '0;
      pend_m[d] = 0; acc_cnt[d] = 0; dok_cnt[d] = 0;
      last_acc_cyc[d] = 0; last_dok_cyc[d] = 0; last_rdata[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;

    // addr_ok must stay low while rst is held, even with req asserted
    req[0] = 1'b1;
    repeat (2) tick();
    req[0] = 1'b0;
    check32("pending_after_rst", 32'(u_a.pending_q), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      issue(0, 1'b1, SZ_W, 32'(i << 2), init_word(0, i));
      issue(1, 1'b1, SZ_W, 32'(i << 2), init_word(1, i));
    end
    drain(0);
    drain(1);

    issue(0, 1'b1, SZ_W, 32'h40, 32'hDEADBEEF);
    t0 = last_acc_cyc[0];
    drain(0);
    check32("wr_latency", 32'(last_dok_cyc[0] - t0), 32'd2);
    check32("wr_resp_zero", last_rdata[0], 32'h0);

    issue(0, 1'b0, SZ_W, 32'h40, 32'h0);
    t0 = last_acc_cyc[0];
    drain(0);
    check32("rd_latency", 32'(last_dok_cyc[0] - t0), 32'd2);
    check32("rd_word", last_rdata[0], 32'hDEADBEEF);

    issue(0, 1'b1, SZ_B, 32'h42, 32'h005A0000);
    issue(0, 1'b0, SZ_W, 32'h40, 32'h0);
    drain(0);
    check32("rd_after_byte", last_rdata[0], 32'hDE5ABEEF);

    issue(0, 1'b1, SZ_H, 32'h40, 32'h00001234);
    issue(0, 1'b0, SZ_W, 32'h40, 32'h0);
    drain(0);
    check32("rd_after_half", last_rdata[0], 32'hDE5A1234);

    issue(0, 1'b1, SZ_W, 32'h41, 32'hFFFFFFFF);
    drain(0);
    check32("misaligned_wr_resp", last_rdata[0], 32'h0);
    issue(0, 1'b0, SZ_W, 32'h40, 32'h0);
    drain(0);
    check32("mem_after_misaligned", last_rdata[0], 32'hDE5A1234);
    issue(0, 1'b1, 2'b11, 32'h40, 32'hFFFFFFFF);
    drain(0);
    check32("illegal_wr_resp", last_rdata[0], 32'h0);
    issue(0, 1'b0, SZ_H, 32'h41, 32'h0);
    drain(0);
    check32("misaligned_rd_zero", last_rdata[0], 32'h0);
    issue(0, 1'b0, SZ_W, 32'h40, 32'h0);
    drain(0);
    check32("mem_after_illegal", last_rdata[0], 32'hDE5A1234);

    // Back-to-back reads against the LATENCY=4 instance
    rd_log[1].delete();
    n = 0;
    req[1] = 1'b1; wr[1] = 1'b0; size[1] = SZ_W; addr[1] = 32'h0;
    for (int i = 0; i < 30 && n < 4; i++) begin
      tick();
      if (obs_ok[1]) begin
        acc_c[n] = cyc - 1;
        n++;
        addr[1] = 32'(n * 4);
      end
    end
    req[1] = 1'b0;
    drain(1);
    check32("b2b_accepted", 32'(n), 32'd4);
`ifndef SRAM_LIKE_SLAVE_STALL_EN
    if (n == 4) begin
      check32("b2b_gap_req2", 32'(acc_c[1] - acc_c[0]), 32'd1);
      check32("b2b_gap_req3", 32'(acc_c[2] - acc_c[0]), 32'd5);
      check32("b2b_gap_req4", 32'(acc_c[3] - acc_c[0]), 32'd6);
    end
`endif
    check32("b2b_resp_count", 32'(rd_log[1].size()), 32'd4);
    for (int k = 0; k < 4 && k < rd_log[1].size(); k++) begin
      check32($sformatf("b2b_order_%0d", k), rd_log[1][k], init_word(1, k));
    end

    // Reset one cycle after accepting a read
    dok_cnt[0] = 0;
    issue(0, 1'b0, SZ_W, 32'h40, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (6) tick();
    check32("rst_no_data_ok", 32'(dok_cnt[0]), 32'd0);
    check32("rst_pending_zero", 32'(u_a.pending_q), 32'd0);
    issue(0, 1'b0, SZ_W, 32'h40, 32'h0);
    drain(0);
    check32("rst_mem_intact", last_rdata[0], 32'hDE5A1234);

`ifdef SRAM_LIKE_SLAVE_STALL_EN
    acc_cnt[0] = 0;
    dok_cnt[0] = 0;
    req[0] = 1'b1; wr[0] = 1'b0; size[0] = SZ_W; addr[0] = 32'h40;
    repeat (64) tick();
    req[0] = 1'b0;
    drain(0);
    check32("stall_some_accepted", 32'(acc_cnt[0] > 0), 32'd1);
    check32("stall_all_answered", 32'(dok_cnt[0]), 32'(acc_cnt[0]));
`endif

    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        req[d]   = ($urandom_range(0, 9) < 7);
        wr[d]    = 1'($urandom_range(0, 1));
        size[d]  = 2'($urandom_range(0, 3));
        addr[d]  = {16'($urandom), 9'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
        wdata[d] = $urandom;
      end
      tick();
    end
    req[0] = 1'b0;
    req[1] = 1'b0;
    drain(0);
    drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
